// File: rtl/sdram_port_arbiter.sv
// Purpose: shares one SDRAM controller command port between a video burst reader (priority) and a CPU.
// Latency: mem_req one cycle after the IDLE decision; cpu_ack one cycle after mem_done; video beats pass through combinationally.
// Backpressure: mem_* held stable until mem_gnt; requesters hold req until their ack; CPU is guaranteed a slot after STARVE_MAX video grants.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_sdram,
    input  logic                rst,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_addr,
    output logic                vid_ack,
    output logic                vid_rvalid,
    output logic                vid_last,
    output logic [DATA_W-1:0]   vid_rdata,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [3:0]          mem_len,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_done
);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]        VID_LEN    = 4'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT  = BCNT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] BEAT_SAT   = BCNT_W'(BURST_LEN);
    localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, REQ_V, REQ_C, WAIT_V, WAIT_C} state_t;

    state_t            state;
    logic [BCNT_W-1:0] beat_cnt;
    logic [SCNT_W-1:0] starve_cnt;
    logic              cpu_win;

    // During the cpu_ack cycle the CPU has not yet had a chance to drop cpu_req,
    // so it cannot win that decision, but it still counts as pending for starvation.
    assign cpu_win = cpu_req && !cpu_ack && (!vid_req || starve_cnt == STARVE_LIM);

    assign vid_ack    = (state == REQ_V) && mem_gnt;
    assign vid_rvalid = (state == WAIT_V) && mem_rvalid;
    assign vid_rdata  = vid_rvalid ? mem_rdata : '0;
    assign vid_last   = vid_rvalid && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk_sdram or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            mem_len    <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_win) begin
                        state      <= REQ_C;
                        mem_req    <= 1'b1;
                        mem_we     <= cpu_we;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_we ? cpu_wdata : '0;
                        mem_be     <= cpu_we ? cpu_be : '1;
                        mem_len    <= '0;
                        starve_cnt <= '0;
                    end else if (vid_req) begin
                        state     <= REQ_V;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= vid_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        mem_len   <= VID_LEN;
                        if (!cpu_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_LIM)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                REQ_V: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT_V;
                    end
                end
                REQ_C: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT_C;
                    end
                end
                WAIT_V: begin
                    // Saturate one past the last beat so overrun beats never re-raise vid_last.
                    if (mem_rvalid && beat_cnt != BEAT_SAT)
                        beat_cnt <= beat_cnt + 1'b1;
                    if (mem_done) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end
                end
                WAIT_C: begin
                    if (mem_rvalid && !mem_we)
                        cpu_rdata <= mem_rdata;
                    if (mem_done) begin
                        cpu_ack <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: drivers push expected commands/beats into queues,
// a controller model answers mem_req, and a monitor pops and compares at negedge.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 24, DATA_W = 32, BURST_LEN = 8, STARVE_MAX = 4, BE_W = 4;

    logic              clk_sdram = 1'b0;
    logic              rst = 1'b1;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_ack, vid_rvalid, vid_last;
    logic [DATA_W-1:0] vid_rdata;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [BE_W-1:0]   cpu_be = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [3:0]        mem_len;
    logic              mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_done = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
                         .STARVE_MAX(STARVE_MAX)) dut (
        .clk_sdram(clk_sdram), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rvalid(vid_rvalid),
        .vid_last(vid_last), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_len(mem_len), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    always #5 clk_sdram = ~clk_sdram;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } cpu_cmd_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] vid_cmd_q[$];
    cpu_cmd_t          cpu_cmd_q[$];
    beat_t             beat_q[$];
    logic [DATA_W-1:0] cpu_rd_q[$];
    int                nbeats_q[$];
    bit                owner_q[$];   // 1 = video, 0 = CPU
    int  gnt_delay = -1;
    bit  gap_en = 1'b0;
    bit  done_sep = 1'b0;
    int  beats_seen = 0;
    bit  cur_vid = 1'b1;
    bit  cur_we = 1'b0;
    bit  done_prev_c = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int i);
        if (a == 24'h003333 && i == 0) return 32'h12345678;
        return {a[7:0] ^ 8'h5A, a} + 32'(i) * 32'h01010101;
    endfunction

    // ---------------- requesters ----------------
    task automatic vid_burst(input logic [ADDR_W-1:0] a, input int nb, input bit push_owner);
        int t;
        vid_cmd_q.push_back(a);
        nbeats_q.push_back(nb);
        for (int i = 0; i < nb; i++) beat_q.push_back('{data: beat_data(a, i), last: (i == BURST_LEN - 1)});
        if (push_owner) owner_q.push_back(1'b1);
        vid_req = 1'b1;
        vid_addr = a;
        t = 0;
        do begin @(negedge clk_sdram); t++; end while (!vid_ack && t < 400);
        if (!vid_ack) fail_now("vid_ack_timeout");
        @(posedge clk_sdram); #1;
        vid_req = 1'b0;
        @(posedge clk_sdram); #1;
    endtask

    task automatic cpu_access(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                              input logic [BE_W-1:0] be, input bit push_owner);
        int t;
        cpu_cmd_q.push_back('{we: we, addr: a, wdata: (we ? wd : '0), be: (we ? be : 4'hF)});
        if (!we) cpu_rd_q.push_back(beat_data(a, 0));
        if (push_owner) owner_q.push_back(1'b0);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
        t = 0;
        do begin @(negedge clk_sdram); t++; end while (!cpu_ack && t < 400);
        if (!cpu_ack) fail_now("cpu_ack_timeout");
        @(posedge clk_sdram); #1;
        cpu_req = 1'b0;
        @(posedge clk_sdram); #1;
    endtask

    // ---------------- controller model ----------------
    task automatic ctl_abort();
        // Controller is reset too, but leaves a stray beat on the bus that must be ignored.
        mem_gnt = 1'b0; mem_done = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        while (rst) begin @(posedge clk_sdram); #1; end
        @(posedge clk_sdram); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic ctl_tick(output bit ab);
        @(posedge clk_sdram); #1;
        ab = rst;
        if (ab) ctl_abort();
    endtask

    task automatic ctl_serve();
        int d, nb;
        bit ab, is_vid, we;
        logic [ADDR_W-1:0] a;
        d = (gnt_delay >= 0) ? gnt_delay : int'($urandom_range(0, 3));
        for (int k = 0; k < d; k++) begin ctl_tick(ab); if (ab) return; end
        mem_gnt = 1'b1;
        a = mem_addr; we = mem_we; is_vid = (mem_len != 4'd0);
        ctl_tick(ab);
        mem_gnt = 1'b0;
        if (ab) return;
        if (is_vid) nb = (nbeats_q.size() > 0) ? nbeats_q.pop_front() : BURST_LEN;
        else nb = we ? 0 : 1;
        for (int i = 0; i < nb; i++) begin
            if (gap_en && $urandom_range(0, 2) == 0) begin ctl_tick(ab); if (ab) return; end
            mem_rvalid = 1'b1; mem_rdata = beat_data(a, i); mem_done = (i == nb - 1) && !done_sep;
            ctl_tick(ab);
            if (ab) return;
            mem_rvalid = 1'b0; mem_rdata = '0; mem_done = 1'b0;
        end
        if (nb == 0 || done_sep) begin
            mem_done = 1'b1;
            ctl_tick(ab);
            if (ab) return;
            mem_done = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_sdram); #1;
            if (!rst && mem_req) ctl_serve();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk_sdram);
            if (rst) begin
                check("quiet_in_reset", 64'({vid_rvalid, vid_ack, cpu_ack, mem_req}), 64'd0);
                done_prev_c = 1'b0;
                cur_vid = 1'b1;
                continue;
            end
            if (done_prev_c || cpu_ack) check("cpu_ack_after_done", 64'(cpu_ack), 64'(done_prev_c));
            if (cpu_ack && done_prev_c && !cur_we) begin
                if (cpu_rd_q.size() == 0) fail_now("cpu_rdata_unexpected");
                else check("cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_q.pop_front()));
            end
            if (mem_req && mem_gnt) begin
                if (owner_q.size() == 0) fail_now("unexpected_grant");
                else begin
                    cur_vid = owner_q.pop_front();
                    beats_seen = 0;
                    check("grant_owner_vid_ack", 64'(vid_ack), 64'(cur_vid));
                    if (cur_vid) begin
                        if (vid_cmd_q.size() == 0) fail_now("vid_cmd_missing");
                        else check("vid_mem_addr", 64'(mem_addr), 64'(vid_cmd_q.pop_front()));
                        check("vid_mem_fields", 64'({mem_we, mem_be, mem_len, mem_wdata}),
                              64'({1'b0, 4'hF, 4'(BURST_LEN - 1), 32'h0}));
                    end else if (cpu_cmd_q.size() == 0) fail_now("cpu_cmd_missing");
                    else begin
                        cpu_cmd_t c;
                        c = cpu_cmd_q.pop_front();
                        cur_we = c.we;
                        check("cpu_mem_cmd", 64'({mem_we, mem_addr, mem_be, mem_len}),
                              64'({c.we, c.addr, c.be, 4'd0}));
                        check("cpu_mem_wdata", 64'(mem_wdata), 64'(c.wdata));
                    end
                end
            end else if (vid_ack) fail_now("vid_ack_without_grant");
            if (vid_rvalid) begin
                beats_seen++;
                if (beat_q.size() == 0) fail_now("unexpected_vid_beat");
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("vid_rdata", 64'(vid_rdata), 64'(b.data));
                    check("vid_last", 64'(vid_last), 64'(b.last));
                end
            end else if (vid_last) fail_now("vid_last_without_rvalid");
            done_prev_c = mem_done && !cur_vid;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((beat_q.size() + owner_q.size() + cpu_rd_q.size() != 0 || mem_req) && t < 3000) begin
            @(negedge clk_sdram); t++;
        end
        if (t >= 3000) fail_now("drain_timeout");
        repeat (4) @(posedge clk_sdram);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, 64'({vid_ack, vid_rvalid, vid_last, vid_rdata, cpu_ack, mem_req, mem_we, mem_len, mem_be}), 64'd0);
        check({name, "_mem"}, 64'({mem_addr, mem_wdata}), 64'd0);
        check({name, "_cpu_rdata"}, 64'(cpu_rdata), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v_left, c_left, starve, t;
        #3;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk_sdram);
        #2 rst = 1'b0;
        @(posedge clk_sdram); #1;

        // Simultaneous requests from reset: video first, then CPU.
        owner_q.push_back(1'b1);
        owner_q.push_back(1'b0);
        fork
            vid_burst(24'h000500, BURST_LEN, 1'b0);
            cpu_access(1'b0, 24'h000600, 32'h0, 4'h0, 1'b0);
        join
        wait_idle();

        gnt_delay = 3;
        vid_burst(24'h000100, BURST_LEN, 1'b1);
        cpu_access(1'b1, 24'h00ABCD, 32'hDEADBEEF, 4'b0011, 1'b1);
        cpu_access(1'b0, 24'h003333, 32'h0, 4'h0, 1'b1);
        wait_idle();

        // Both requesters saturated: CPU must get every (STARVE_MAX+1)-th slot.
        gnt_delay = -1;
        gap_en = 1'b1;
        v_left = 12; c_left = 3; starve = 0;
        while (v_left > 0 || c_left > 0) begin
            if (c_left > 0 && (v_left == 0 || starve == STARVE_MAX)) begin
                owner_q.push_back(1'b0); c_left--; starve = 0;
            end else begin
                owner_q.push_back(1'b1); v_left--;
                starve = (c_left > 0) ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
            end
        end
        fork
            begin for (int i = 0; i < 12; i++) vid_burst(24'($urandom), BURST_LEN, 1'b0); end
            begin for (int i = 0; i < 3; i++) cpu_access(1'($urandom_range(0, 1)), 24'($urandom), $urandom, 4'($urandom), 1'b0); end
        join
        wait_idle();

        // Early mem_done (no vid_last) and overrun beats (vid_last only on beat BURST_LEN).
        gap_en = 1'b0;
        vid_burst(24'h000700, 5, 1'b1);
        vid_burst(24'h000800, BURST_LEN + 3, 1'b1);
        done_sep = 1'b1;
        vid_burst(24'h000880, BURST_LEN, 1'b1);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            gap_en = 1'($urandom_range(0, 1));
            done_sep = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: vid_burst(24'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : BURST_LEN, 1'b1);
                1: cpu_access(1'b0, 24'($urandom), 32'h0, 4'h0, 1'b1);
                default: cpu_access(1'b1, 24'($urandom), $urandom, 4'($urandom), 1'b1);
            endcase
        end
        wait_idle();

        // Reset during the third beat of a burst.
        gap_en = 1'b0; done_sep = 1'b0; gnt_delay = 0;
        fork
            vid_burst(24'h000900, BURST_LEN, 1'b1);
        join_none
        t = 0;
        while (beats_seen < 3 && t < 200) begin @(negedge clk_sdram); t++; end
        if (beats_seen < 3) fail_now("reset_phase_beat_timeout");
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        beat_q.delete(); vid_cmd_q.delete(); cpu_cmd_q.delete();
        cpu_rd_q.delete(); nbeats_q.delete(); owner_q.delete();
        repeat (3) @(posedge clk_sdram);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk_sdram);
        #1;
        vid_burst(24'h000A00, BURST_LEN, 1'b1);
        cpu_access(1'b0, 24'h000B00, 32'h0, 4'h0, 1'b1);
        cpu_access(1'b0, 24'h003333, 32'h0, 4'h0, 1'b1);
        wait_idle();

        check("leftover_beats", 64'(beat_q.size()), 64'd0);
        check("leftover_grants", 64'(owner_q.size()), 64'd0);
        check("leftover_cpu_reads", 64'(cpu_rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
